// File: rtl/sha_round_sequencer.sv
// Control sequencer for a single-block SHA-256 compression: loads H, starts the W generator,
// steps 64 rounds with K prefetch, triggers the final add and writes the digest words out.
module sha_round_sequencer #(
  parameter int NUMBER_OF_Ks  = 64,
  parameter int NUMBER_OF_Hs  = 8,
  parameter int OUTPUT_LENGTH = 8,
  localparam int KW = $clog2(NUMBER_OF_Ks),
  localparam int HW = $clog2(NUMBER_OF_Hs),
  localparam int OW = $clog2(OUTPUT_LENGTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          w_ready,
  output logic          busy,
  output logic          finish,
  output logic [HW-1:0] hmem_address,
  output logic          hmem_enable,
  output logic          hmem_write,
  output logic          h_load,
  output logic [HW-1:0] h_idx,
  output logic [KW-1:0] kmem_address,
  output logic          kmem_enable,
  output logic          kmem_write,
  output logic          w_init,
  output logic          round_en,
  output logic          w_step,
  output logic [KW-1:0] round_idx,
  output logic          final_add,
  output logic [OW-1:0] dom_address,
  output logic          dom_enable,
  output logic          dom_write
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD_H, S_INIT, S_ROUNDS, S_FINAL, S_WRITE, S_DONE
  } state_e;

  localparam logic [HW-1:0] H_LAST = HW'(NUMBER_OF_Hs - 1);
  localparam logic [KW-1:0] K_LAST = KW'(NUMBER_OF_Ks - 1);
  localparam logic [OW-1:0] O_LAST = OW'(OUTPUT_LENGTH - 1);

  state_e        state_q, state_d;
  logic [HW-1:0] hcnt_q, hcnt_d;
  logic          hdone_q, hdone_d;
  logic          ld_q;
  logic [HW-1:0] ld_idx_q;
  logic [KW-1:0] t_q, t_d;
  logic [OW-1:0] ocnt_q, ocnt_d;

  // ld_q/ld_idx_q delay the H read by one cycle to line h_load up with the memory data.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      hcnt_q   <= '0;
      hdone_q  <= 1'b0;
      ld_q     <= 1'b0;
      ld_idx_q <= '0;
      t_q      <= '0;
      ocnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      hcnt_q   <= hcnt_d;
      hdone_q  <= hdone_d;
      ld_q     <= hmem_enable;
      ld_idx_q <= hmem_address;
      t_q      <= t_d;
      ocnt_q   <= ocnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    hcnt_d       = hcnt_q;
    hdone_d      = hdone_q;
    t_d          = t_q;
    ocnt_d       = ocnt_q;
    busy         = (state_q != S_IDLE);
    finish       = 1'b0;
    hmem_address = '0;
    hmem_enable  = 1'b0;
    hmem_write   = 1'b0;
    h_load       = ld_q;
    h_idx        = ld_idx_q;
    kmem_address = '0;
    kmem_enable  = 1'b0;
    kmem_write   = 1'b0;
    w_init       = 1'b0;
    round_en     = 1'b0;
    w_step       = 1'b0;
    round_idx    = '0;
    final_add    = 1'b0;
    dom_address  = '0;
    dom_enable   = 1'b0;
    dom_write    = 1'b0;
    case (state_q)
      S_IDLE: if (start) state_d = S_LOAD_H;
      S_LOAD_H: begin
        // Eight read cycles, then one drain cycle for the last h_load.
        if (!hdone_q) begin
          hmem_enable  = 1'b1;
          hmem_address = hcnt_q;
          if (hcnt_q == H_LAST) begin
            hdone_d = 1'b1;
            hcnt_d  = '0;
          end else begin
            hcnt_d = hcnt_q + 1'b1;
          end
        end else begin
          hdone_d = 1'b0;
          state_d = S_INIT;
        end
      end
      S_INIT: begin
        w_init      = 1'b1;
        kmem_enable = 1'b1;
        state_d     = S_ROUNDS;
      end
      S_ROUNDS: begin
        round_idx   = t_q;
        kmem_enable = 1'b1;
        if (w_ready) begin
          round_en = 1'b1;
          w_step   = 1'b1;
          if (t_q != K_LAST) begin
            kmem_address = t_q + 1'b1;
            t_d          = t_q + 1'b1;
          end else begin
            kmem_enable = 1'b0;
            t_d         = '0;
            state_d     = S_FINAL;
          end
        end else begin
          // Stall: re-read K[t] so it is valid again when the round finally runs.
          kmem_address = t_q;
        end
      end
      S_FINAL: begin
        final_add = 1'b1;
        state_d   = S_WRITE;
      end
      S_WRITE: begin
        dom_enable  = 1'b1;
        dom_write   = 1'b1;
        dom_address = ocnt_q;
        if (ocnt_q == O_LAST) begin
          ocnt_d  = '0;
          state_d = S_DONE;
        end else begin
          ocnt_d = ocnt_q + 1'b1;
        end
      end
      S_DONE: begin
        finish  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: doc/sha_round_sequencer.md
Name: sha_round_sequencer

Overview:
Central sequencer for the single-block SHA-256 hash datapath. It runs the full compression flow after the message block is assembled: load the 8 initial H words from H memory, initialise the W generator, run 64 rounds with K words prefetched from K memory, do the final H add, write the 8 digest words to output memory, then pulse finish. It drives only control strobes, indices and memory addresses. Hashing arithmetic stays in the datapath.

Parameters:
NUMBER_OF_Ks, 64, number of rounds and K memory depth.
NUMBER_OF_Hs, 8, number of H words loaded.
OUTPUT_LENGTH, 8, number of digest words written to output memory.

Ports:
clk  in  1  clock, all state on rising edge.
reset  in  1  asynchronous, active-low reset.
start  in  1  request to hash the assembled block; sampled only in IDLE.
w_ready  in  1  W generator can supply the next word; low stalls the rounds.
busy  out  1  high in every state except IDLE.
finish  out  1  one-cycle pulse when the digest write completes.
hmem_address  out  clog2(NUMBER_OF_Hs)  H memory read address.
hmem_enable  out  1  H memory read enable.
hmem_write  out  1  tied 0.
h_load  out  1  hmem data valid this cycle; datapath latches it into H[h_idx] and working register[h_idx].
h_idx  out  clog2(NUMBER_OF_Hs)  target index for h_load.
kmem_address  out  clog2(NUMBER_OF_Ks)  K memory read address.
kmem_enable  out  1  K memory read enable.
kmem_write  out  1  tied 0.
w_init  out  1  one-cycle pulse; W generator loads W0..W15 from the block.
round_en  out  1  datapath executes round round_idx this cycle.
w_step  out  1  W generator advances; equals round_en.
round_idx  out  clog2(NUMBER_OF_Ks)  current round number.
final_add  out  1  one-cycle pulse; datapath computes H[i] += working[i].
dom_address  out  clog2(OUTPUT_LENGTH)  output memory write address; also the digest word select.
dom_enable  out  1  output memory enable.
dom_write  out  1  output memory write strobe.

Behaviour:
- Reset (async, reset=0): go to IDLE. All outputs are 0, all counters are 0. Reset asserted mid-operation aborts at once; no further memory accesses occur.
- Memories have 1-cycle read latency: data is valid the cycle after the enable/address cycle.
- State sequence: IDLE -> LOAD_H -> INIT -> ROUNDS -> FINAL -> WRITE -> DONE -> IDLE.
- IDLE: start=1 moves to LOAD_H on the next edge. start in any other state is ignored, not queued.
- LOAD_H: 9 cycles.
  - Cycles j=0..7: hmem_enable=1, hmem_address=j.
  - Cycles j=1..8: h_load=1, h_idx=j-1.
- INIT: 1 cycle. w_init=1, kmem_enable=1, kmem_address=0 (K prefetch).
- ROUNDS, cycle with counter t:
  - If w_ready=1: round_en=w_step=1, round_idx=t. If t<NUMBER_OF_Ks-1, also kmem_enable=1 and kmem_address=t+1. Then t increments.
  - If w_ready=0 (stall): round_en=w_step=0, t holds. kmem_enable=1 and kmem_address=t, so K[t] is re-read and valid again next cycle.
  - After the round with t=NUMBER_OF_Ks-1, go to FINAL and clear t.
- FINAL: 1 cycle, final_add=1.
- WRITE: OUTPUT_LENGTH cycles. dom_enable=dom_write=1, dom_address=0..OUTPUT_LENGTH-1 in increasing order.
- DONE: 1 cycle. finish=1, busy=1. Next cycle is IDLE with busy=0.
- Latency with no stalls: start sampled at edge 0 gives finish high in cycle 84 (9+1+64+1+8+1). Each stall cycle adds 1.
- Counters wrap-safe: the round counter never exceeds NUMBER_OF_Ks-1 and the H/output counters never exceed their depth-1. Addresses outside the active states are driven to 0.
- Strobes never overlap: at most one of h_load, w_init, round_en, final_add, dom_write is high in any cycle.
- hmem_enable and h_load overlap only in LOAD_H.

Test Plan:
- Reset then start=1 for one cycle, w_ready=1 -> hmem_address 0..7 in cycles 1..8, h_load cycles 2..9, w_init at cycle 10 with kmem_address=0, round_idx 0..63 in cycles 11..74, final_add cycle 75, dom_address 0..7 in cycles 76..83, finish cycle 84.
- w_ready=0 for 3 cycles at round 20 -> round_en low 3 cycles, kmem_address=20 held, round 20 executes after release, finish at cycle 87.
- start held high continuously -> second hash begins only after return to IDLE; exactly one finish pulse per run, with finish at cycle 84 then the next run's LOAD_H starting cycle 86.
- reset asserted at round 30 -> all outputs 0 asynchronously, no dom_write ever seen; after deassert plus start, a full clean 84-cycle run.
- Round 63 -> kmem_enable=0 that cycle, no kmem_address 64 wrap.
- Assertion check over all runs -> mutually exclusive strobes, hmem_write=kmem_write=0 always, busy=0 only in IDLE.
